// File: rtl/speech_if.sv
// speech_if: phrase-address handshake between the sequencer and the speech player.
interface speech_if #(
    parameter int ADDR_W = 16
);
    logic              addr_valid;
    logic              addr_ready;
    logic              phrase_done;
    logic [ADDR_W-1:0] address;
    modport master (output addr_valid, output address, input addr_ready, input phrase_done);
    modport slave  (input addr_valid, input address, output addr_ready, output phrase_done);
endinterface

// File: rtl/speech_sequencer.sv
// speech_sequencer: encodes emotion/action/stage into an aligned phrase address and schedules it
// to the speech player with cooldown, a one-deep pending request and context-change auto-trigger.
module speech_sequencer #(
    parameter int EMO_W           = 8,
    parameter int SPECIAL_W       = 3,
    parameter int STAGE_W         = 2,
    parameter int VARIANT_BITS    = 1,
    parameter int ALIGN_BITS      = 5,
    parameter int ADDR_W          = 16,
    parameter int COOLDOWN_CYCLES = 4,
    parameter bit AUTO_TRIGGER    = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [EMO_W-1:0]     emotional_state_i,
    input  logic [SPECIAL_W-1:0] special_action_i,
    input  logic [STAGE_W-1:0]   development_stage_i,
    input  logic                 speak_req_i,
    input  logic                 mute_i,
    speech_if.master             player,
    output logic                 busy_o
);
    localparam int EI    = EMO_W > 1 ? $clog2(EMO_W) : 1;
    localparam int AC    = $clog2(SPECIAL_W + 1);
    localparam int CTX_W = STAGE_W + AC + EI;
    localparam int CW    = COOLDOWN_CYCLES > 1 ? $clog2(COOLDOWN_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, COOLDOWN} state_e;

    state_e                  state_q, state_d;
    logic [EI-1:0]           emo_idx;
    logic [AC-1:0]           act_code;
    logic [CTX_W-1:0]        ctx, last_ctx_q, last_ctx_d;
    logic [VARIANT_BITS-1:0] variant_q, variant_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic                    pending_q, pending_d;
    logic                    valid_q, valid_d;
    logic                    trigger;

    // Scanning from the top down leaves the lowest set bit as the winner.
    always_comb begin
        emo_idx  = '0;
        act_code = '0;
        for (int i = EMO_W - 1; i >= 0; i--)
            if (emotional_state_i[i]) emo_idx = EI'(i);
        for (int i = SPECIAL_W - 1; i >= 0; i--)
            if (special_action_i[i]) act_code = AC'(i + 1);
    end

    assign ctx     = {development_stage_i, act_code, emo_idx};
    assign trigger = !mute_i && (speak_req_i || pending_q || (AUTO_TRIGGER && ctx != last_ctx_q));

    always_comb begin
        state_d    = state_q;
        last_ctx_d = last_ctx_q;
        variant_d  = variant_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        valid_d    = valid_q;
        pending_d  = pending_q | speak_req_i;
        unique case (state_q)
            IDLE: if (trigger) begin
                state_d    = ISSUE;
                valid_d    = 1'b1;
                pending_d  = 1'b0;
                last_ctx_d = ctx;
                addr_d     = ADDR_W'({ctx, variant_q}) << ALIGN_BITS;
            end
            ISSUE: if (player.addr_ready) begin
                state_d   = WAIT_DONE;
                valid_d   = 1'b0;
                variant_d = variant_q + 1'b1;
            end
            WAIT_DONE: if (player.phrase_done) begin
                state_d = COOLDOWN_CYCLES == 0 ? IDLE : COOLDOWN;
                cnt_d   = CW'(COOLDOWN_CYCLES - 1);
            end
            COOLDOWN: begin
                cnt_d   = cnt_q - 1'b1;
                state_d = cnt_q == '0 ? IDLE : COOLDOWN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_ctx_q <= '0;
            variant_q  <= '0;
            cnt_q      <= '0;
            addr_q     <= '0;
            valid_q    <= 1'b0;
            pending_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_ctx_q <= last_ctx_d;
            variant_q  <= variant_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            pending_q  <= pending_d;
        end
    end

    assign player.addr_valid = valid_q;
    assign player.address    = addr_q;
    assign busy_o            = state_q != IDLE;
endmodule

// File: tb/tb_speech_sequencer.sv
// tb_speech_sequencer: directed and randomized phrase scheduling checked against a transaction model.
module tb_speech_sequencer;
    localparam int CD = 4;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic [7:0] es   = '0;
    logic [2:0] sa   = '0;
    logic [1:0] st   = '0;
    logic       req  = 1'b0;
    logic       mute = 1'b0;
    logic       busy;
    int         vectors = 0;
    int         miscompares = 0;
    int         m_var = 0;
    int         m_last = 0;
    logic [15:0] m_exp = '0;

    speech_if #(.ADDR_W(16)) sp ();

    speech_sequencer #(.COOLDOWN_CYCLES(CD)) dut (
        .clk(clk), .rst(rst),
        .emotional_state_i(es), .special_action_i(sa), .development_stage_i(st),
        .speak_req_i(req), .mute_i(mute),
        .player(sp), .busy_o(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic int f_emo(input logic [7:0] e);
        for (int i = 0; i < 8; i++) if (e[i]) return i;
        return 0;
    endfunction

    function automatic int f_act(input logic [2:0] a);
        for (int i = 0; i < 3; i++) if (a[i]) return i + 1;
        return 0;
    endfunction

    function automatic int f_ctx(input logic [7:0] e, input logic [2:0] a, input logic [1:0] s);
        return s * 32 + f_act(a) * 8 + f_emo(e);
    endfunction

    function automatic logic [15:0] f_addr(input int c, input int v);
        return 16'((c * 2 + v) * 32);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present inputs while idle; an issue is expected on a request or a context change.
    task automatic start(input logic [7:0] e, input logic [2:0] a, input logic [1:0] s, input bit r);
        int c;
        bit trig;
        c    = f_ctx(e, a, s);
        trig = !mute && (r || c != m_last);
        es = e; sa = a; st = s; req = r;
        tick;
        req = 1'b0;
        chk("issue_valid", sp.addr_valid, trig);
        if (trig) begin
            m_exp  = f_addr(c, m_var);
            m_last = c;
            chk("issue_addr", sp.address, m_exp);
            chk("issue_busy", busy, 1);
        end
    endtask

    // Stall, handshake, play and cool down; optionally request during cooldown and serve it.
    task automatic finish_phrase(input int rdly_in, input int ddly_in, input bit pend_in, input logic [7:0] alt);
        int rdly = rdly_in, ddly = ddly_in;
        bit pend = pend_in;
        bit more = 1'b1;
        logic [7:0] es0;
        while (more) begin
            es0 = es;
            for (int i = 0; i < rdly; i++) begin
                es = (i % 2 == 0) ? alt : es0;
                sp.phrase_done = 1'($urandom_range(0, 1));
                tick;
                sp.phrase_done = 1'b0;
                chk("stall_valid", sp.addr_valid, 1);
                chk("stall_addr", sp.address, m_exp);
            end
            es = es0;
            sp.addr_ready  = 1'b1;
            sp.phrase_done = 1'($urandom_range(0, 1));
            tick;
            sp.addr_ready  = 1'b0;
            sp.phrase_done = 1'b0;
            m_var = (m_var + 1) % 2;
            chk("hs_valid", sp.addr_valid, 0);
            chk("hs_busy", busy, 1);
            for (int i = 0; i < ddly; i++) begin
                tick;
                chk("wait_busy", busy, 1);
            end
            sp.phrase_done = 1'b1;
            tick;
            sp.phrase_done = 1'b0;
            for (int i = 1; i <= CD; i++) begin
                chk("cd_busy", busy, 1);
                req = pend && i == 2;
                tick;
                req = 1'b0;
            end
            chk("cd_idle", busy, 0);
            tick;
            if (pend) begin
                m_exp = f_addr(f_ctx(es, sa, st), m_var);
                chk("pend_valid", sp.addr_valid, 1);
                chk("pend_addr", sp.address, m_exp);
                pend = 1'b0;
                rdly = $urandom_range(0, 3);
                ddly = $urandom_range(0, 3);
            end else begin
                chk("no_reissue", sp.addr_valid, 0);
                more = 1'b0;
            end
        end
    endtask

    initial begin
        sp.addr_ready  = 1'b0;
        sp.phrase_done = 1'b0;
        tick;
        tick;
        chk("rst_valid", sp.addr_valid, 0);
        chk("rst_addr", sp.address, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        tick;
        chk("post_rst_quiet", sp.addr_valid, 0);
        tick;
        chk("post_rst_busy", busy, 0);

        start(8'h04, 3'b010, 2'd2, 1'b1);
        chk("plan_addr0", sp.address, 16'h1480);
        finish_phrase(10, 2, 1'b1, 8'h80);

        start(8'h01, 3'b000, 2'd0, 1'b0);
        finish_phrase(1, 1, 1'b0, 8'h01);
        start(8'h80, 3'b000, 2'd0, 1'b0);
        chk("auto_emo_bits", sp.address[8:6], 7);
        finish_phrase(0, 0, 1'b0, 8'h80);
        tick;
        chk("auto_steady", sp.addr_valid, 0);

        start(8'h0A, 3'b110, 2'd0, 1'b1);
        chk("prio_addr", sp.address, 16'h0440);
        finish_phrase(2, 0, 1'b0, 8'h55);
        start(8'h00, 3'b110, 2'd0, 1'b1);
        chk("zero_emo_bits", sp.address[8:6], 0);
        finish_phrase(0, 1, 1'b0, 8'h00);

        mute = 1'b1;
        req  = 1'b1;
        tick;
        req = 1'b0;
        chk("mute_valid", sp.addr_valid, 0);
        chk("mute_busy", busy, 0);
        es = 8'h10;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("mute_hold", sp.addr_valid, 0);
        end
        mute = 1'b0;
        tick;
        m_exp  = f_addr(f_ctx(es, sa, st), m_var);
        m_last = f_ctx(es, sa, st);
        chk("unmute_valid", sp.addr_valid, 1);
        chk("unmute_addr", sp.address, m_exp);
        mute = 1'b1;
        tick;
        chk("mute_keeps_valid", sp.addr_valid, 1);
        rst = 1'b1; req = 1'b1; mute = 1'b0;
        es = '0; sa = '0; st = '0;
        tick;
        chk("midrst_valid", sp.addr_valid, 0);
        chk("midrst_addr", sp.address, 0);
        chk("midrst_busy", busy, 0);
        m_var = 0;
        m_last = 0;
        rst = 1'b0; req = 1'b0;
        tick;
        chk("rst_beats_req", sp.addr_valid, 0);
        tick;
        chk("rst_idle", busy, 0);

        for (int n = 0; n < 30; n++) begin
            start(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 1'b1);
            finish_phrase($urandom_range(0, 4), $urandom_range(0, 4), 1'($urandom_range(0, 1)),
                          8'($urandom_range(0, 255)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
